bcd_timekeeper: RTL and testbench
=================================

BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: input clock frequency in Hz; must be >= 2.
REQ-002 SHALL have parameter TICK_HZ, default 1: time-advance rate in Hz; must divide CLK_FREQ.
REQ-003 SHALL have port clk  in  1: single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port mode_24h  in  1: display format, 1=24h, 0=12h with AM/PM.
REQ-006 SHALL have port set_valid  in  1: load request, sampled each cycle.
REQ-007 SHALL have port set_time  in  24: BCD {hr_t,hr_u,min_t,min_u,sec_t,sec_u}, interpreted per mode_24h.
REQ-008 SHALL have port set_pm  in  1: PM flag for a 12h-mode load; ignored in 24h mode.
REQ-009 SHALL have port alarm_we  in  1: alarm register write strobe.
REQ-010 SHALL have port alarm_hhmm  in  16: BCD {hr_t,hr_u,min_t,min_u}, always 24h encoding.
REQ-011 SHALL have port alarm_en  in  1: alarm enable level.
REQ-012 SHALL have port time_bcd  out  24: displayed time, same digit order as set_time.
REQ-013 SHALL have port is_am  out  1: 1 when internal hour is 00-11.
REQ-014 SHALL have port tick  out  1: one-cycle pulse at every time advance.
REQ-015 SHALL have port set_err  out  1: one-cycle pulse when a set or alarm write is rejected.
REQ-016 SHALL have port alarm_hit  out  1: one-cycle alarm pulse.

Function
REQ-017 SHALL keep time internally as 24h BCD hh:mm:ss (hour 00-23), independent of mode_24h.
REQ-018 SHALL run a prescaler counting 0..CLK_FREQ/TICK_HZ-1 and assert tick for one cycle at terminal count.
REQ-019 SHALL advance on a tick cycle by +1 s at the next edge: sec 59->00 carries to min; min 59->00 carries to hour; hour 23->00 wraps.
REQ-020 SHALL clock every register from clk with tick and carries used only as enables; derived or ripple clocks are forbidden.
REQ-021 SHALL drive time_bcd, is_am and alarm_hit registered and reflecting the current internal state; mode_24h affects decode only, and a mode change alters time_bcd combinationally within the same cycle without altering state.
REQ-022 SHALL apply this 12h decode: internal 00 -> 12 AM; 01-11 -> same AM; 12 -> 12 PM; 13-23 -> minus 12, PM.
REQ-023 SHALL accept a set_valid load with sec/min tens 0-5 and units 0-9 plus a valid hour (24h: 00-23; 12h: 01-12, converted with set_pm by the inverse of REQ-022), at the next edge, and SHALL clear the prescaler to 0.
REQ-024 SHALL, on an invalid set (non-BCD digit or out-of-range field), leave state unchanged and pulse set_err on the next cycle.
REQ-025 SHALL give set_valid priority over tick in the same cycle: the loaded value is taken without an increment, and the next tick occurs CLK_FREQ/TICK_HZ cycles later.
REQ-026 SHALL load alarm_hhmm on alarm_we when it is a valid 24h hh:mm; an invalid value is rejected per REQ-024.
REQ-027 SHALL pulse alarm_hit for one cycle only when a tick-driven advance lands on alarm hh:mm:00 and alarm_en=1; loads never trigger it.
REQ-028 SHALL, when set_valid and alarm_we are both valid in the same cycle, perform both operations; set_err reports either rejection.

Reset
REQ-029 SHALL, while rst_n=0, immediately force: time 00:00:00, prescaler 0, alarm 00:00, tick=0, set_err=0, alarm_hit=0, is_am=1.
REQ-030 SHALL show 12:00:00 in 12h mode and 00:00:00 in 24h mode after reset.
REQ-031 SHALL abort any pending load or alarm on reset assertion mid-operation; nothing is retained.

Structure
REQ-032 SHALL use a shared package timekeeper_pkg holding the BCD digit width, digit-field offsets within time_bcd/alarm_hhmm, and limit constants (59, 23, 12).
REQ-033 SHALL contain one sub-module, tick_gen (parameters CLK_FREQ, TICK_HZ; ports clk, rst_n, clr, tick); the rest is flat.

Verification (CLK_FREQ=10, TICK_HZ=1)
REQ-034 SHALL cover: reset with mode_24h=0 -> time_bcd=12:00:00, is_am=1; with mode_24h=1 -> 00:00:00.
REQ-035 SHALL cover: 12h set 11:59:59 with set_pm=0, one tick -> 12:00:00, is_am=0.
REQ-036 SHALL cover: 24h set 23:59:59, one tick -> 00:00:00, is_am=1, and 12h view shows 12:00:00.
REQ-037 SHALL cover: 12h set hour 13, or 24h set sec_t=6 -> set_err pulses one cycle, time unchanged.
REQ-038 SHALL cover: alarm 07:30 with alarm_en=1, set 07:29:59, tick -> alarm_hit for exactly one cycle; repeating with alarm_en=0 -> no pulse.
REQ-039 SHALL cover: set_valid coincident with tick loading 05:00:00 -> time 05:00:00 with no increment, and the next tick exactly 10 cycles later.

Source files
------------

// File: rtl/timekeeper_pkg.sv
// Shared constants, digit offsets and BCD helpers
// for the BCD timekeeper.
package timekeeper_pkg;

  localparam int DIGIT_W = 4;
  localparam int PAIR_W  = 2 * DIGIT_W;

  localparam int SEC_U_LSB = 0;
  localparam int SEC_T_LSB = 4;
  localparam int MIN_U_LSB = 8;
  localparam int MIN_T_LSB = 12;
  localparam int HR_U_LSB  = 16;
  localparam int HR_T_LSB  = 20;

  localparam int AL_MIN_U_LSB = 0;
  localparam int AL_MIN_T_LSB = 4;
  localparam int AL_HR_U_LSB  = 8;
  localparam int AL_HR_T_LSB  = 12;

  localparam logic [PAIR_W-1:0] SEC_MAX = 8'h59;
  localparam logic [PAIR_W-1:0] MIN_MAX = 8'h59;
  localparam logic [PAIR_W-1:0] HR_MAX  = 8'h23;
  localparam logic [PAIR_W-1:0] HR_NOON = 8'h12;

  typedef logic [PAIR_W-1:0] bcd2_t;

  typedef struct packed {
    bcd2_t hr;
    bcd2_t min;
    bcd2_t sec;
  } hms_t;

  // both digits decimal and value within [0, max]
  function automatic logic bcd2_ok(
    input bcd2_t v,
    input bcd2_t max
  );
    return (v[3:0] <= 4'd9) &&
           (v[7:4] <= 4'd9) &&
           (v <= max);
  endfunction

  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 24h hour -> 12h display hour
  function automatic bcd2_t hr_to_12(input bcd2_t h);
    if (h == 8'h00)
      return HR_NOON;
    if (h <= HR_NOON)
      return h;
    if (h[7:4] == 4'd1)
      return {4'd0, h[3:0] - 4'd2};
    if (h[3:0] <= 4'd1)
      return {4'd0, h[3:0] + 4'd8};
    return {4'd1, h[3:0] - 4'd2};
  endfunction

  // 12h hour (01-12) plus PM flag -> 24h hour
  function automatic bcd2_t hr_from_12(
    input bcd2_t h,
    input logic  pm
  );
    if (h == HR_NOON)
      return pm ? HR_NOON : 8'h00;
    if (!pm)
      return h;
    if (h[7:4] == 4'd1)
      return {4'd2, h[3:0] + 4'd2};
    if (h[3:0] <= 4'd7)
      return {4'd1, h[3:0] + 4'd2};
    return {4'd2, h[3:0] - 4'd8};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every
// CLK_FREQ/TICK_HZ clocks; clr restarts the count.
module tick_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // next count: clear, wrap at terminal, else step
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick)
      cnt_d = '0;
  end

  // prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// 24h BCD time-of-day counter with 12h/24h view,
// validated load and a daily hh:mm alarm.
module bcd_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_24h,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  input  logic        set_pm,
  input  logic        alarm_we,
  input  logic [15:0] alarm_hhmm,
  input  logic        alarm_en,
  output logic [23:0] time_bcd,
  output logic        is_am,
  output logic        tick,
  output logic        set_err,
  output logic        alarm_hit
);

  hms_t        time_q, time_d;
  logic [15:0] alarm_q, alarm_d;
  logic        set_err_q, set_err_d;
  logic        alarm_hit_q, alarm_hit_d;

  hms_t  set_hms;
  hms_t  inc_hms;
  bcd2_t set_hr, set_min, set_sec;
  bcd2_t al_hr, al_min;
  logic  set_hr_ok;
  logic  set_ok;
  logic  al_ok;
  logic  load;

  tick_gen #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (load),
    .tick (tick)
  );

  // validate and convert the load and alarm requests
  always_comb begin
    set_hr  = set_time[HR_U_LSB  +: PAIR_W];
    set_min = set_time[MIN_U_LSB +: PAIR_W];
    set_sec = set_time[SEC_U_LSB +: PAIR_W];
    al_hr   = alarm_hhmm[AL_HR_U_LSB  +: PAIR_W];
    al_min  = alarm_hhmm[AL_MIN_U_LSB +: PAIR_W];
    if (mode_24h)
      set_hr_ok = bcd2_ok(set_hr, HR_MAX);
    else
      set_hr_ok = bcd2_ok(set_hr, HR_NOON) &&
                  (set_hr != 8'h00);
    set_ok = set_hr_ok &&
             bcd2_ok(set_min, MIN_MAX) &&
             bcd2_ok(set_sec, SEC_MAX);
    al_ok  = bcd2_ok(al_hr, HR_MAX) &&
             bcd2_ok(al_min, MIN_MAX);
    set_hms.hr  = mode_24h ? set_hr :
                  hr_from_12(set_hr, set_pm);
    set_hms.min = set_min;
    set_hms.sec = set_sec;
    load = set_valid && set_ok;
  end

  // one-second advance with sec/min/hour carries
  always_comb begin
    inc_hms = time_q;
    if (time_q.sec == SEC_MAX) begin
      inc_hms.sec = '0;
      if (time_q.min == MIN_MAX) begin
        inc_hms.min = '0;
        if (time_q.hr == HR_MAX)
          inc_hms.hr = '0;
        else
          inc_hms.hr = bcd2_inc(time_q.hr);
      end else begin
        inc_hms.min = bcd2_inc(time_q.min);
      end
    end else begin
      inc_hms.sec = bcd2_inc(time_q.sec);
    end
  end

  // next state: load beats tick, alarm only on advance
  always_comb begin
    time_d      = time_q;
    alarm_d     = alarm_q;
    set_err_d   = (set_valid && !set_ok) ||
                  (alarm_we && !al_ok);
    alarm_hit_d = 1'b0;
    if (load)
      time_d = set_hms;
    else if (tick)
      time_d = inc_hms;
    if (alarm_we && al_ok)
      alarm_d = alarm_hhmm;
    if (tick && !load && alarm_en &&
        inc_hms.hr  == alarm_q[AL_HR_U_LSB  +: PAIR_W] &&
        inc_hms.min == alarm_q[AL_MIN_U_LSB +: PAIR_W] &&
        inc_hms.sec == 8'h00)
      alarm_hit_d = 1'b1;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q      <= '0;
      alarm_q     <= '0;
      set_err_q   <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      time_q      <= time_d;
      alarm_q     <= alarm_d;
      set_err_q   <= set_err_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  // display decode; mode only changes the hour view
  always_comb begin
    time_bcd = {mode_24h ? time_q.hr :
                hr_to_12(time_q.hr),
                time_q.min, time_q.sec};
    is_am    = (time_q.hr < HR_NOON);
  end

  assign set_err   = set_err_q;
  assign alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed bench for bcd_timekeeper
// with CLK_FREQ=10, TICK_HZ=1.
module tb_bcd_timekeeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_24h;
  logic        set_valid;
  logic [23:0] set_time;
  logic        set_pm;
  logic        alarm_we;
  logic [15:0] alarm_hhmm;
  logic        alarm_en;
  logic [23:0] time_bcd;
  logic        is_am;
  logic        tick;
  logic        set_err;
  logic        alarm_hit;

  int n_vec = 0;
  int n_err = 0;
  int n;

  bcd_timekeeper #(
    .CLK_FREQ(10),
    .TICK_HZ (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_24h  (mode_24h),
    .set_valid (set_valid),
    .set_time  (set_time),
    .set_pm    (set_pm),
    .alarm_we  (alarm_we),
    .alarm_hhmm(alarm_hhmm),
    .alarm_en  (alarm_en),
    .time_bcd  (time_bcd),
    .is_am     (is_am),
    .tick      (tick),
    .set_err   (set_err),
    .alarm_hit (alarm_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [23:0] obs,
    input logic [23:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    while (tick !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    mode_24h   = 1'b0;
    set_valid  = 1'b0;
    set_time   = '0;
    set_pm     = 1'b0;
    alarm_we   = 1'b0;
    alarm_hhmm = '0;
    alarm_en   = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_12h", time_bcd, 24'h120000);
    chk("rst_am", {23'b0, is_am}, 24'd1);
    chk("rst_tick", {23'b0, tick}, 24'd0);
    chk("rst_err", {23'b0, set_err}, 24'd0);
    chk("rst_hit", {23'b0, alarm_hit}, 24'd0);
    mode_24h = 1'b1;
    #1;
    chk("rst_24h", time_bcd, 24'h000000);
    @(negedge clk);
    rst_n = 1'b1;

    // 12h load 11:59:59 AM, tick into noon
    mode_24h  = 1'b0;
    set_time  = 24'h115959;
    set_pm    = 1'b0;
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    chk("ld_1159", time_bcd, 24'h115959);
    chk("ld_1159_am", {23'b0, is_am}, 24'd1);
    chk("ld_1159_err", {23'b0, set_err}, 24'd0);
    wait_tick(n);
    chk("ld_1159_lat", n, 24'd9);
    @(negedge clk);
    chk("noon", time_bcd, 24'h120000);
    chk("noon_am", {23'b0, is_am}, 24'd0);
    chk("noon_tick1", {23'b0, tick}, 24'd0);
    mode_24h = 1'b1;
    #1;
    chk("noon_24h", time_bcd, 24'h120000);

    // 24h load 23:59:59, wrap to midnight
    @(negedge clk);
    set_time  = 24'h235959;
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    chk("ld_2359", time_bcd, 24'h235959);
    chk("ld_2359_am", {23'b0, is_am}, 24'd0);
    wait_tick(n);
    @(negedge clk);
    chk("mid_24h", time_bcd, 24'h000000);
    chk("mid_am", {23'b0, is_am}, 24'd1);
    mode_24h = 1'b0;
    #1;
    chk("mid_12h", time_bcd, 24'h120000);

    // 12h PM load 08:15:00 PM -> 20:15:00
    @(negedge clk);
    set_time  = 24'h081500;
    set_pm    = 1'b1;
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    set_pm    = 1'b0;
    chk("pm_12h", time_bcd, 24'h081500);
    chk("pm_am", {23'b0, is_am}, 24'd0);
    mode_24h = 1'b1;
    #1;
    chk("pm_24h", time_bcd, 24'h201500);

    // rejected loads leave time alone
    @(negedge clk);
    set_time  = 24'h102030;
    set_valid = 1'b1;
    @(negedge clk);
    mode_24h  = 1'b0;
    set_time  = 24'h135959;
    @(negedge clk);
    set_valid = 1'b0;
    mode_24h  = 1'b1;
    chk("bad_h13_err", {23'b0, set_err}, 24'd1);
    chk("bad_h13_t", time_bcd, 24'h102030);
    @(negedge clk);
    chk("bad_h13_err0", {23'b0, set_err}, 24'd0);
    set_time  = 24'h081560;
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    chk("bad_s6_err", {23'b0, set_err}, 24'd1);
    chk("bad_s6_t", time_bcd, 24'h102030);
    alarm_hhmm = 16'h2400;
    alarm_we   = 1'b1;
    @(negedge clk);
    alarm_we = 1'b0;
    chk("bad_al_err", {23'b0, set_err}, 24'd1);
    @(negedge clk);
    chk("bad_al_err0", {23'b0, set_err}, 24'd0);

    // alarm 07:30 enabled, set and alarm together
    alarm_hhmm = 16'h0730;
    alarm_we   = 1'b1;
    alarm_en   = 1'b1;
    set_time   = 24'h072959;
    set_valid  = 1'b1;
    @(negedge clk);
    alarm_we  = 1'b0;
    set_valid = 1'b0;
    chk("al_ld_hit", {23'b0, alarm_hit}, 24'd0);
    chk("al_ld_err", {23'b0, set_err}, 24'd0);
    wait_tick(n);
    @(negedge clk);
    chk("al_t", time_bcd, 24'h073000);
    chk("al_hit", {23'b0, alarm_hit}, 24'd1);
    @(negedge clk);
    chk("al_hit1", {23'b0, alarm_hit}, 24'd0);

    // same again with alarm disabled
    alarm_en  = 1'b0;
    set_time  = 24'h072959;
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    wait_tick(n);
    @(negedge clk);
    chk("al_dis_t", time_bcd, 24'h073000);
    chk("al_dis_hit", {23'b0, alarm_hit}, 24'd0);

    // load coincident with tick
    wait_tick(n);
    chk("co_tick", {23'b0, tick}, 24'd1);
    set_time  = 24'h050000;
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    chk("co_t", time_bcd, 24'h050000);
    chk("co_tick0", {23'b0, tick}, 24'd0);
    wait_tick(n);
    chk("co_lat", n, 24'd9);
    chk("co_pre", time_bcd, 24'h050000);
    @(negedge clk);
    chk("co_post", time_bcd, 24'h050001);

    // reset mid-load discards the request
    set_time  = 24'h222222;
    set_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_async", time_bcd, 24'h000000);
    @(negedge clk);
    chk("mr_t", time_bcd, 24'h000000);
    chk("mr_err", {23'b0, set_err}, 24'd0);
    chk("mr_tick", {23'b0, tick}, 24'd0);
    set_valid = 1'b0;
    rst_n     = 1'b1;
    mode_24h  = 1'b0;
    #1;
    chk("mr_12h", time_bcd, 24'h120000);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
